// File: rtl/chebyshev_term_sequencer.sv
// Streams Chebyshev terms T_0..T_N for one fixed-point argument using
// T_k = 2*x*T_(k-1) - T_(k-2) on a single shared multiply/subtract with saturation.
module chebyshev_term_sequencer #(
   parameter int WL    = 16,
   parameter int FRAC  = 12,
   parameter int ORD_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WL-1:0]    x_in,
   input  logic [ORD_W-1:0] order_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WL-1:0]    out_data,
   output logic [ORD_W-1:0] out_index,
   output logic             out_last,
   output logic             out_sat,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EMIT, MUL, ADD} state_t;

   localparam logic [WL-1:0] ONE = {{(WL-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic signed [2*WL:0] D_MAX = $signed({{(WL+2){1'b0}}, {(WL-1){1'b1}}});
   localparam logic signed [2*WL:0] D_MIN = $signed({{(WL+2){1'b1}}, {(WL-1){1'b0}}});
   localparam logic [WL-1:0] W_MAX = {1'b0, {(WL-1){1'b1}}};
   localparam logic [WL-1:0] W_MIN = {1'b1, {(WL-1){1'b0}}};

   state_t                  state;
   logic signed [WL-1:0]    x_r;
   logic        [ORD_W-1:0] n_r;
   logic signed [WL-1:0]    cur;
   logic signed [WL-1:0]    prev;
   logic signed [2*WL-1:0]  product;
   logic        [ORD_W-1:0] idx;
   logic                    sat;
   logic                    last;

   logic signed [2*WL-1:0]  t;
   logic signed [2*WL:0]    d;
   logic        [WL-1:0]    result;
   logic                    clip;
   logic        [ORD_W-1:0] idx_inc;

   assign out_data  = cur;
   assign out_index = idx;
   assign out_sat   = sat;
   assign out_last  = last;
   assign idx_inc   = idx + ORD_W'(1);

   // Shifting by FRAC-1 rather than FRAC folds in the recurrence's factor of 2.
   always_comb begin
      t      = product >>> (FRAC-1);
      d      = {t[2*WL-1], t} - {{(WL+1){prev[WL-1]}}, prev};
      clip   = 1'b1;
      result = W_MAX;
      if (d > D_MAX) begin
         result = W_MAX;
      end else if (d < D_MIN) begin
         result = W_MIN;
      end else begin
         result = d[WL-1:0];
         clip   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         x_r         <= '0;
         n_r         <= '0;
         cur         <= '0;
         prev        <= '0;
         product     <= '0;
         idx         <= '0;
         sat         <= 1'b0;
         last        <= 1'b0;
         out_valid   <= 1'b0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  x_r         <= x_in;
                  n_r         <= order_in;
                  cur         <= ONE;
                  prev        <= '0;
                  idx         <= '0;
                  sat         <= 1'b0;
                  last        <= (order_in == '0);
                  state       <= EMIT;
                  out_valid   <= 1'b1;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (idx == n_r) begin
                     state       <= IDLE;
                     out_valid   <= 1'b0;
                     start_ready <= 1'b1;
                     busy        <= 1'b0;
                  end else if (idx == '0) begin
                     // T_1 is x itself, so it skips the multiplier.
                     prev <= cur;
                     cur  <= x_r;
                     sat  <= 1'b0;
                     idx  <= ORD_W'(1);
                     last <= (n_r == ORD_W'(1));
                  end else begin
                     state     <= MUL;
                     out_valid <= 1'b0;
                  end
               end
            end
            MUL: begin
               product <= (2*WL)'(x_r) * (2*WL)'(cur);
               state   <= ADD;
            end
            ADD: begin
               prev      <= cur;
               cur       <= result;
               sat       <= clip;
               idx       <= idx_inc;
               last      <= (idx_inc == n_r);
               state     <= EMIT;
               out_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/chebyshev_term_sequencer.md
Name: chebyshev_term_sequencer

Overview:
- Generates the Chebyshev polynomial terms T_0(x)..T_N(x) for one fixed-point argument x, one term at a time.
- Uses the recurrence T_k = 2*x*T_(k-1) - T_(k-2) on a single shared multiplier/subtractor, with saturation back to the datapath word length.
- Sits between the argument source and the downstream Chebyshev coefficient MAC.
- Accepts one job per start handshake and streams the terms out over a valid/ready interface.

Parameters:
- WL, 16, word length of x and of every term; two's complement.
- FRAC, 12, fractional bits; must satisfy FRAC <= WL-2 so that 1.0 is representable.
- ORD_W, 5, width of the order and index fields; maximum order is 2^ORD_W - 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start_valid  in  1  job request.
- start_ready  out  1  sequencer idle and able to accept a job.
- x_in  in  WL  argument x, signed, Q(WL-FRAC).FRAC.
- order_in  in  ORD_W  highest term index N to produce.
- out_valid  out  1  out_data holds a term.
- out_ready  in  1  consumer accepts the term.
- out_data  out  WL  term T_k, same Q format as x_in.
- out_index  out  ORD_W  k.
- out_last  out  1  asserted with the term where k == N.
- out_sat  out  1  term k was clipped by saturation.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n == 0 at a clock edge): FSM goes to IDLE. out_valid, out_data, out_index, out_last, out_sat, busy and all internal registers (x, N, cur, prev, product) clear to 0. start_ready = 1 after reset.
- Reset asserted mid-job aborts the job immediately. No further terms are emitted, and the next job starts clean.
- start_ready = (state == IDLE). It is a registered state decode, not combinational on the inputs.
- FSM states and transitions:
  - IDLE: on start_valid & start_ready, capture x_in and order_in. Set cur = 1<<FRAC, prev = 0, index = 0. Go to EMIT.
  - EMIT: out_valid = 1, presenting cur, index, last = (index == N), and the sat flag. out_data, out_index, out_last and out_sat are held stable until out_ready.
  - On out_ready in EMIT:
    - if index == N: go to IDLE; out_valid drops next cycle.
    - else if index == 0: set prev = cur, cur = x, sat = 0, index = 1; stay in EMIT.
    - else: go to MUL.
  - MUL: register product = x * cur (signed, 2*WL bits). Go to ADD.
  - ADD: compute the next term (arithmetic below). Set prev = cur, cur = result, sat = clip flag, index = index + 1. Go to EMIT.
- Throughput: T_0 and T_1 are emitted on back-to-back cycles when out_ready is held high. T_k for k >= 2 costs 3 cycles each (EMIT, MUL, ADD).
- First out_valid appears 1 cycle after the start handshake.
- Arithmetic in ADD:
  - t = product >>> (FRAC-1). This is an arithmetic shift: truncation toward minus infinity, which also folds in the factor 2.
  - d = t - sign-extended prev, computed in 2*WL+1 bits.
  - If d > 2^(WL-1)-1: result = 2^(WL-1)-1 and sat = 1.
  - Else if d < -2^(WL-1): result = -2^(WL-1) and sat = 1.
  - Otherwise: result = d[WL-1:0] and sat = 0.
- Saturated values are fed back unchanged into later recurrence steps. There is no sticky flag beyond the per-term out_sat.
- T_0 and T_1 never have out_sat set.
- order_in = 0 produces exactly one beat: T_0 = 1<<FRAC, with out_last = 1.
- Index never wraps: N <= 2^ORD_W - 1 and the job ends at index == N.
- start_valid while busy is ignored (start_ready = 0); the requester must hold it.
- out_ready while out_valid = 0 has no effect.
- In the cycle the last beat is accepted, start_ready is still 0. A new job can be accepted one cycle later.

Test Plan:
- Nominal (WL=16, FRAC=12), x_in=2048 (0.5), order_in=4, out_ready held 1 -> out_data 4096, 2048, -2048, -4096, -2048 with index 0..4. out_last only on index 4; out_sat always 0. Beats at cycles +1, +2, +5, +8, +11 after the handshake.
- Positive saturation, x_in=28672 (7.0), order_in=2 -> terms 4096, 28672, 32767; out_sat=1 only on T_2.
- Negative saturation, x_in=-28672, order_in=3 -> T_2=32767 with sat=1, then T_3=-32768 with sat=1.
- Truncation, x_in=-1, order_in=3 -> terms 4096, -1, -4096, 3.
- Order zero and handshakes:
  - order_in=0 -> single beat 4096 with out_last=1; start_ready returns 1 two cycles after the start handshake.
  - start_valid pulsed while busy -> the pulse is ignored.
- Backpressure and reset:
  - out_ready low for 5 cycles on the index-2 beat -> out_data, out_index and out_sat are held stable, and no index skips.
  - rst_n low for 1 cycle during MUL -> next cycle out_valid=0 and start_ready=1.
  - A new job (x_in=2048, order_in=4) after that reset reproduces the nominal sequence exactly.
